// File: rtl/libv_cpa_seq.sv
// Sequential carry-propagate adder: resolves a save/carry pair K bits per cycle into W-bit sum.
// Define LIBV_CPA_SEQ_OVF_EN to add the registered signed-overflow output out_ovf.
module libv_cpa_seq #(
  parameter int unsigned W = 32,
  parameter int unsigned K = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_s,
  input  logic [W-1:0] in_c,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_sum,
  output logic         out_co,
`ifdef LIBV_CPA_SEQ_OVF_EN
  output logic         out_ovf,
`endif
  input  logic         out_rdy
);

  localparam int unsigned NC   = W / K;
  localparam int unsigned CntW = (NC > 1) ? $clog2(NC) : 1;
  localparam int unsigned IdxW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NC - 1);

  if ((W % K) != 0) begin : g_param_err
    $error("libv_cpa_seq: W must be a multiple of K");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    s_q, s_d;
  logic [W-1:0]    c_q, c_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            co_q, co_d;
  logic [IdxW-1:0] base;
  logic [K:0]      chunk_sum;
  logic            accept;
`ifdef LIBV_CPA_SEQ_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  assign base    = IdxW'(K * cnt_q);
  assign in_rdy  = (state_q == StIdle) | ((state_q == StDone) & out_rdy);
  assign out_vld = (state_q == StDone);
  assign out_sum = sum_q;
  assign out_co  = co_q;
  assign accept  = in_vld & in_rdy;
`ifdef LIBV_CPA_SEQ_OVF_EN
  assign out_ovf = ovf_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    s_d       = s_q;
    c_d       = c_q;
    sum_d     = sum_q;
    co_d      = co_q;
`ifdef LIBV_CPA_SEQ_OVF_EN
    ovf_d     = ovf_q;
`endif
    chunk_sum = {1'b0, s_q[base +: K]} + {1'b0, c_q[base +: K]} + {{K{1'b0}}, carry_q};
    unique case (state_q)
      StBusy: begin
        sum_d[base +: K] = chunk_sum[K-1:0];
        carry_d          = chunk_sum[K];
        cnt_d            = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          co_d    = chunk_sum[K];
`ifdef LIBV_CPA_SEQ_OVF_EN
          // Carry into the MSB differs from carry out of it on signed overflow.
          ovf_d   = (s_q[W-1] ^ c_q[W-1] ^ chunk_sum[K-1]) ^ chunk_sum[K];
`endif
        end
      end
      StDone: begin
        if (out_rdy) state_d = StIdle;
      end
      default: ;
    endcase
    // Acceptance overrides the DONE exit, giving back-to-back operation.
    if (accept) begin
      s_d     = in_s;
      c_d     = in_c;
      cnt_d   = '0;
      carry_d = 1'b0;
      state_d = StBusy;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_q     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
`ifdef LIBV_CPA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
`ifdef LIBV_CPA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_libv_cpa_seq.sv
// Scoreboard bench for libv_cpa_seq: W=32/K=8 main instance plus a K=32 instance.
`timescale 1ns/1ps
module tb_libv_cpa_seq;

  localparam int unsigned W  = 32;
  localparam int unsigned K  = 8;
  localparam int unsigned NC = W / K;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_vld = 1'b0, in_rdy, out_vld, out_co, out_rdy = 1'b1;
  logic [W-1:0] in_s = '0, in_c = '0, out_sum;
  logic         u_in_vld = 1'b0, u_in_rdy, u_out_vld, u_out_co, u_out_rdy = 1'b1;
  logic [W-1:0] u_in_s = '0, u_in_c = '0, u_out_sum;
`ifdef LIBV_CPA_SEQ_OVF_EN
  logic         out_ovf, u_out_ovf;
`endif

  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;
  bit   rdy_rand = 1'b0;
  logic vld_prev = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  libv_cpa_seq #(.W(W), .K(K)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_s    (in_s),
    .in_c    (in_c),
    .in_rdy  (in_rdy),
    .out_vld (out_vld),
    .out_sum (out_sum),
    .out_co  (out_co),
`ifdef LIBV_CPA_SEQ_OVF_EN
    .out_ovf (out_ovf),
`endif
    .out_rdy (out_rdy)
  );

  libv_cpa_seq #(.W(W), .K(W)) dut_k32 (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (u_in_vld),
    .in_s    (u_in_s),
    .in_c    (u_in_c),
    .in_rdy  (u_in_rdy),
    .out_vld (u_out_vld),
    .out_sum (u_out_sum),
    .out_co  (u_out_co),
`ifdef LIBV_CPA_SEQ_OVF_EN
    .out_ovf (u_out_ovf),
`endif
    .out_rdy (u_out_rdy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: plain wide unsigned addition; signed overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] s, input logic [W-1:0] c);
    exp_t        e;
    logic [W:0]  full;
    full  = {1'b0, s} + {1'b0, c};
    e.sum = full[W-1:0];
    e.co  = full[W];
    e.ovf = (s[W-1] == c[W-1]) && (e.sum[W-1] != s[W-1]);
    e.acc = cyc;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Call right after a negedge; holds the pair until accepted and records the expectation.
  task automatic send(input logic [W-1:0] s, input logic [W-1:0] c);
    int n = 0;
    in_vld = 1'b1;
    in_s   = s;
    in_c   = c;
    #1;
    while (!in_rdy && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_rdy) begin
      nchk++;
      nerr++;
      $display("FAIL send timeout: in_rdy stayed 0 for %0d cycles, required 1", n);
    end else begin
      exp_q.push_back(model(s, c));
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_vld = 1'b0;
    in_s   = W'($urandom);
    in_c   = W'($urandom);
  endtask

  task automatic wait_vld();
    int n = 0;
    #1;
    while (!out_vld && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("wait out_vld", out_vld, 1);
  endtask

  always @(negedge clk) if (rdy_rand) out_rdy = ($urandom_range(0, 3) != 0);

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        vld_prev = 1'b0;
        continue;
      end
      if (out_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected result", 1, 0);
        end else begin
          e = exp_q[0];
          chk("out_sum", out_sum, e.sum);
          chk("out_co", out_co, e.co);
`ifdef LIBV_CPA_SEQ_OVF_EN
          chk("out_ovf", out_ovf, e.ovf);
`endif
          if (!vld_prev) chk("latency", cyc - e.acc, NC + 1);
          chk("in_rdy in DONE", in_rdy, out_rdy);
          if (out_rdy) void'(exp_q.pop_front());
        end
      end else begin
        chk("in_rdy idle/busy", in_rdy,
            (exp_q.size() == 0) || (exp_q.size() == 1 && exp_q[0].acc == cyc));
      end
      vld_prev = out_vld & ~out_rdy;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int acc;
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset out_vld", out_vld, 0);
    chk("reset out_sum", out_sum, 0);
    chk("reset out_co", out_co, 0);
    chk("reset in_rdy", in_rdy, 1);

    out_rdy = 1'b1;
    @(negedge clk); send(32'h0000_00FF, 32'h0000_0001);
    idle();
    @(negedge clk); send(32'hFFFF_FFFF, 32'h0000_0001);
    @(negedge clk); send(32'h7FFF_FFFF, 32'h0000_0001);
    idle();
    repeat (8) @(negedge clk);

    // Stall in DONE, then release with a new pair accepted on the same edge.
    out_rdy = 1'b0;
    send(32'h0000_1234, 32'h0000_4321);
    @(negedge clk);
    wait_vld();
    in_vld = 1'b1;
    in_s   = 32'hDEAD_BEEF;
    in_c   = 32'h1111_1111;
    repeat (10) @(negedge clk);
    out_rdy = 1'b1;
    #1;
    chk("b2b in_rdy", in_rdy, 1);
    send(32'hDEAD_BEEF, 32'h1111_1111);
    idle();
    repeat (8) @(negedge clk);

    // Reset during BUSY discards the operation.
    send(32'hAAAA_AAAA, 32'h5555_5555);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid-busy reset out_vld", out_vld, 0);
    chk("mid-busy reset out_sum", out_sum, 0);
    @(negedge clk);
    rst    = 1'b0;
    in_vld = 1'b0;
    #1;
    chk("post-reset out_sum", out_sum, 0);
    chk("post-reset in_rdy", in_rdy, 1);
    @(negedge clk); send(32'h1234_5678, 32'h1111_1111);
    idle();
    repeat (8) @(negedge clk);

    // Randomised traffic with random gaps and consumer back-pressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      @(negedge clk);
      send(rand_word(), rand_word());
    end
    idle();
    rdy_rand = 1'b0;
    out_rdy  = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain queue", exp_q.size(), 0);

    // K == W instance: single-cycle BUSY.
    @(negedge clk);
    u_out_rdy = 1'b0;
    u_in_vld  = 1'b1;
    u_in_s    = 32'h8000_0000;
    u_in_c    = 32'h8000_0000;
    #1;
    chk("k32 in_rdy", u_in_rdy, 1);
    acc = cyc;
    @(negedge clk);
    u_in_vld = 1'b0;
    #1;
    n = 0;
    while (!u_out_vld && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("k32 latency", cyc - acc, 2);
    chk("k32 out_sum", u_out_sum, 0);
    chk("k32 out_co", u_out_co, 1);
`ifdef LIBV_CPA_SEQ_OVF_EN
    chk("k32 out_ovf", u_out_ovf, 1);
`endif
    @(negedge clk);
    #1;
    chk("k32 hold out_vld", u_out_vld, 1);
    u_out_rdy = 1'b1;
    @(negedge clk);
    #1;
    chk("k32 released out_vld", u_out_vld, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
